reset_sequencer: RTL and testbench

//  Generates the stretched, handshaked active-low reset that drives the ARSTN input of a
//  far-domain reset synchronizer, e.g. the second clock domain of the async FIFO.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/bit_sync.sv | 22 ++
 rtl/reset_sequencer.sv | 118 +++++++++++
 tb/tb_reset_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the far-domain reset sequencer.
// Optional timeout support is selected by RESET_SEQ_TIMEOUT_EN in reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_LOW,
    WAIT_HIGH,
    SETTLE
  } state_e;

  localparam int unsigned ASSERT_CYCLES_DEF  = 16;
  localparam int unsigned RELEASE_CYCLES_DEF = 4;
  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // Sizes the shared counter so no phase can wrap it.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain, asynchronously cleared to 0.
module bit_sync
  import reset_seq_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Stretched, handshaked active-low reset generator for a far clock domain.
// Define RESET_SEQ_TIMEOUT_EN to bound the wait states and enable timeout_err.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned ASSERT_CYCLES  = ASSERT_CYCLES_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic arstn,
  input  logic rst_req,
  input  logic far_srstn,
  output logic rst_out_n,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam int unsigned CNT_W =
    $clog2(max3(ASSERT_CYCLES, RELEASE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic             far_n;
  logic             expired_c;

  bit_sync #(.STAGES(SYNC_STAGES)) u_far_sync (
    .clk   (clk),
    .rst_n (arstn),
    .d     (far_srstn),
    .q     (far_n)
  );

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_STEP    = CNT_W'(1);
  assign expired_c = (cnt == TIMEOUT_LAST);
`else
  // Without a timeout the wait counter is frozen so it cannot wrap.
  localparam logic [CNT_W-1:0] WAIT_STEP    = CNT_W'(0);
  assign expired_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= ASSERT;
      cnt         <= '0;
      rst_out_n   <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      pend        <= 1'b0;
    end else begin
      done <= 1'b0;
      // Requests arriving mid-sequence (including the final SETTLE cycle) are queued.
      if (rst_req && (state != IDLE)) pend <= 1'b1;

      case (state)
        IDLE: begin
          if (rst_req || pend) begin
            state     <= ASSERT;
            cnt       <= '0;
            pend      <= 1'b0;
            rst_out_n <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (!far_n || expired_c) begin
            state     <= WAIT_HIGH;
            rst_out_n <= 1'b1;
            cnt       <= '0;
            if (far_n) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + WAIT_STEP;
          end
        end
        WAIT_HIGH: begin
          if (far_n || expired_c) begin
            state <= SETTLE;
            cnt   <= '0;
            if (!far_n) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + WAIT_STEP;
          end
        end
        SETTLE: begin
          if (cnt == RELEASE_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer with a 2-flop far-domain reset model.
// Build with RESET_SEQ_TIMEOUT_EN defined to exercise the timeout path.
module tb_reset_sequencer;

  logic clk;
  logic arstn;
  logic rst_req;
  logic far_srstn;
  logic rst_out_n;
  logic busy;
  logic done;
  logic timeout_err;
  logic hold_high;
  logic [1:0] far_q;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int sb[$];
  int exp_cyc;

  reset_sequencer #(
    .ASSERT_CYCLES  (4),
    .RELEASE_CYCLES (2),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .arstn       (arstn),
    .rst_req     (rst_req),
    .far_srstn   (far_srstn),
    .rst_out_n   (rst_out_n),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Far domain: its synchronized reset follows rst_out_n through two flops.
  always @(posedge clk or negedge rst_out_n) begin
    if (!rst_out_n) far_q <= 2'b00;
    else            far_q <= {far_q[0], 1'b1};
  end
  assign far_srstn = hold_high ? 1'b1 : far_q[1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Issues a one-cycle request; returns the edge at which ASSERT is entered.
  task automatic pulse_req(output int s);
    s = cyc + 1;
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
  endtask

  // Monitor: every DONE pulse must match the next expected completion cycle.
  always @(negedge clk) begin
    if (arstn && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", cyc, -1);
      end else begin
        exp_cyc = sb.pop_front();
        chk("done_cycle", cyc, exp_cyc);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    int s;
    int c0;
    arstn     = 1'b0;
    rst_req   = 1'b0;
    hold_high = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_rst_out_n", int'(rst_out_n), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);

    // Power-on sequence
    c0 = cyc;
    sb.push_back(c0 + 12);
    arstn = 1'b1;
    wait_cyc(c0 + 4);
    chk("poweron_low_4", int'(rst_out_n), 0);
    wait_cyc(c0 + 5);
    chk("poweron_release", int'(rst_out_n), 1);
    wait_cyc(c0 + 16);
    chk("poweron_idle_busy", int'(busy), 0);
    chk("poweron_sb_empty", sb.size(), 0);

    // Single soft request
    chk("soft_pre_rst_out_n", int'(rst_out_n), 1);
    pulse_req(s);
    chk("soft_rst_out_n_low", int'(rst_out_n), 0);
    chk("soft_busy", int'(busy), 1);
    sb.push_back(s + 12);
    wait_cyc(s + 16);
    chk("soft_sb_empty", sb.size(), 0);

    // Requests during ASSERT and SETTLE merge into exactly one extra sequence
    pulse_req(s);
    wait_cyc(s + 1);
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    wait_cyc(s + 10);
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
    sb.push_back(s + 12);
    sb.push_back(s + 25);
    wait_cyc(s + 12);
    chk("pend_rst_out_n_at_done", int'(rst_out_n), 1);
    wait_cyc(s + 13);
    chk("pend_second_assert", int'(rst_out_n), 0);
    wait_cyc(s + 32);
    chk("pend_sb_empty", sb.size(), 0);
    chk("pend_idle_busy", int'(busy), 0);

    // ARSTN during WAIT_HIGH aborts and restarts
    pulse_req(s);
    wait_cyc(s + 6);
    chk("abort_pre_rst_out_n", int'(rst_out_n), 1);
    arstn = 1'b0;
    #1;
    chk("abort_async_rst_out_n", int'(rst_out_n), 0);
    chk("abort_async_busy", int'(busy), 1);
    wait_cyc(s + 7);
    arstn = 1'b1;
    sb.push_back(s + 19);
    wait_cyc(s + 24);
    chk("abort_sb_empty", sb.size(), 0);

    // Far domain never acknowledges reset entry
    hold_high = 1'b1;
    pulse_req(s);
`ifdef RESET_SEQ_TIMEOUT_EN
    sb.push_back(s + 23);
    wait_cyc(s + 19);
    chk("tmo_still_waiting", int'(rst_out_n), 0);
    chk("tmo_err_before", int'(timeout_err), 0);
    wait_cyc(s + 20);
    chk("tmo_release", int'(rst_out_n), 1);
    chk("tmo_err_set", int'(timeout_err), 1);
    wait_cyc(s + 28);
    chk("tmo_sb_empty", sb.size(), 0);
    hold_high = 1'b0;
    pulse_req(s);
    sb.push_back(s + 12);
    wait_cyc(s + 16);
    chk("tmo_err_sticky", int'(timeout_err), 1);
    chk("tmo_second_sb_empty", sb.size(), 0);
    arstn = 1'b0;
    #1;
    chk("tmo_err_cleared", int'(timeout_err), 0);
    @(negedge clk);
    c0 = cyc;
    sb.push_back(c0 + 12);
    arstn = 1'b1;
    wait_cyc(c0 + 16);
    chk("tmo_poweron_sb_empty", sb.size(), 0);
`else
    wait_cyc(s + 1000);
    chk("hang_busy", int'(busy), 1);
    chk("hang_timeout_err", int'(timeout_err), 0);
    chk("hang_rst_out_n", int'(rst_out_n), 0);
    c0 = cyc;
    hold_high = 1'b0;
    sb.push_back(c0 + 10);
    wait_cyc(c0 + 14);
    chk("resume_sb_empty", sb.size(), 0);
    chk("resume_idle_busy", int'(busy), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
